// File: rtl/ft_alu_pipe.sv
// Dual-channel fault-tolerant add/sub: primary/shadow datapaths per channel, Hamming-corrected sums,
// bounded retry on disagreement. Define FT_ALU_ERR_CNT_EN to add the saturating err_cnt output.
module ft_alu_pipe #(
  parameter int unsigned W         = 3,
  parameter int unsigned RETRY_MAX = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         par,
  input  logic [2:0]   ctl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         xc,
  output logic         yc,
  output logic [1:0]   xe,
  output logic [1:0]   ye
`ifdef FT_ALU_ERR_CNT_EN
  , output logic [7:0] err_cnt
`endif
);

  function automatic int ham_p(input int w);
    int p;
    p = 0;
    for (int i = 1; i <= 16; i++) begin
      if (p == 0 && (1 << i) >= w + i + 1) p = i;
    end
    return p;
  endfunction

  localparam int P = ham_p(int'(W));
  localparam int N = int'(W) + P;
  localparam logic [3:0] RetryLim = 4'(RETRY_MAX);

  // Encode into a Hamming(N, W) codeword, then decode with single-bit correction.
  function automatic logic [W-1:0] ham_fix(input logic [W-1:0] d);
    logic [N:1]   cw;
    logic [W-1:0] sh;
    logic [W-1:0] q;
    logic         pb;
    int           syn;
    cw  = '0;
    sh  = d;
    q   = '0;
    syn = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = sh[0];
        sh      = sh >> 1;
      end
    end
    for (int k = 0; k < P; k++) begin
      pb = 1'b0;
      for (int pos = 1; pos <= N; pos++) begin
        if (((pos >> k) & 1) == 1) pb ^= cw[pos];
      end
      for (int pos = 1; pos <= N; pos++) begin
        if (pos == (1 << k)) cw[pos] = pb;
      end
    end
    for (int k = 0; k < P; k++) begin
      pb = 1'b0;
      for (int pos = 1; pos <= N; pos++) begin
        if (((pos >> k) & 1) == 1) pb ^= cw[pos];
      end
      if (pb) syn = syn | (1 << k);
    end
    for (int pos = 1; pos <= N; pos++) begin
      if (pos == syn) cw[pos] = ~cw[pos];
    end
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) q = {cw[pos], q[W-1:1]};
    end
    return q;
  endfunction

  function automatic logic [W:0] alu(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                     input logic [2:0] fc);
    logic [W-1:0] oa;
    logic [W-1:0] ob;
    logic [W:0]   s;
    oa = fc[2] ? -fa : fa;
    ob = fc[1] ? -fb : fb;
    s  = {1'b0, oa} + {1'b0, ob};
    return {s[W], ham_fix(s[W-1:0])};
  endfunction

  typedef enum logic [1:0] {StIdle, StExec, StCheck, StDone} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] a_q, b_q;
  logic [2:0]   ctl_q;
  logic [3:0]   cnt_q, cnt_d;
  logic [W:0]   xp_q, xs_q, yp_q, ys_q;
  logic [W:0]   xp_res, xs_res, yp_res, ys_res;
  logic [W-1:0] x_d, y_d;
  logic         xc_d, yc_d;
  logic [1:0]   xe_d, ye_d;
  logic         in_ok, x_clean, y_clean;

  assign xp_res = alu(a_q, b_q, ctl_q);
  assign xs_res = alu(a_q, b_q, ctl_q);
  assign yp_res = alu(a_q, b_q, ctl_q);
  assign ys_res = alu(a_q, b_q, ctl_q);

  assign in_ok = (^{a, b, par}) && (ctl == 3'b001 || ctl == 3'b010 || ctl == 3'b100);
  assign x_clean   = (xp_q == xs_q);
  assign y_clean   = (yp_q == ys_q);
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x;
    y_d     = y;
    xc_d    = xc;
    yc_d    = yc;
    xe_d    = xe;
    ye_d    = ye;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cnt_d = '0;
          if (in_ok) begin
            state_d = StExec;
          end else begin
            state_d = StDone;
            x_d     = '0;
            y_d     = '0;
            xc_d    = 1'b0;
            yc_d    = 1'b0;
            xe_d    = 2'b11;
            ye_d    = 2'b11;
          end
        end
      end
      StExec: state_d = StCheck;
      StCheck: begin
        if (!(x_clean && y_clean && xp_q == yp_q) && cnt_q < RetryLim) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = StExec;
        end else begin
          // Primary results are reported even for a channel that never agreed.
          state_d = StDone;
          x_d     = xp_q[W-1:0];
          y_d     = yp_q[W-1:0];
          xc_d    = xp_q[W];
          yc_d    = yp_q[W];
          xe_d    = x_clean ? 2'b10 : 2'b01;
          ye_d    = y_clean ? 2'b10 : 2'b01;
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x       <= '0;
      y       <= '0;
      xc      <= 1'b0;
      yc      <= 1'b0;
      xe      <= 2'b00;
      ye      <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x       <= x_d;
      y       <= y_d;
      xc      <= xc_d;
      yc      <= yc_d;
      xe      <= xe_d;
      ye      <= ye_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      ctl_q <= '0;
      xp_q  <= '0;
      xs_q  <= '0;
      yp_q  <= '0;
      ys_q  <= '0;
    end else begin
      if (state_q == StIdle && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        ctl_q <= ctl;
      end
      if (state_q == StExec) begin
        xp_q <= xp_res;
        xs_q <= xs_res;
        yp_q <= yp_res;
        ys_q <= ys_res;
      end
    end
  end

`ifdef FT_ALU_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && (xe != 2'b10 || ye != 2'b10) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/ft_alu_pipe.md
Name: ft_alu_pipe

Overview:
- Parametrised, sequential successor to the combinational dual-channel fault-tolerant adder/subtractor.
- Accepts one W-bit operand pair per transaction over a valid/ready handshake. Checks the input parity and the one-hot control.
- Computes the result on two channels (X and Y); each channel has a primary and a shadow datapath, both Hamming-corrected.
- Retries on disagreement up to RETRY_MAX times, then reports a per-channel status code. Sits between the operand source and the result consumer.

Parameters:
- W, 3, operand/result width in bits (≥2).
- RETRY_MAX, 2, maximum recomputations after a CHECK mismatch (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept; equals (state==IDLE).
- a  in  W  operand A.
- b  in  W  operand B.
- par  in  1  parity bit; input valid when XOR of all bits of a, b, par = 1 (odd).
- ctl  in  3  one-hot op: 001 A+B, 010 A−B, 100 B−A.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- x, y  out  W  channel results.
- xc, yc  out  1  channel carry-out.
- xe, ye  out  2  channel status: 10 ok, 11 input error, 01 unrecoverable mismatch, 00 only while out_valid=0.

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0; x=y=0; xc=yc=0; xe=ye=00; retry count=0. After deassertion in_ready=1. Reset mid-transaction discards the transaction; no output is produced for it.
- IDLE: on a clk edge with in_valid&in_ready, capture a, b, par, ctl and clear the retry count.
  - If the parity check or the one-hot check fails: go to DONE with x=y=0, xc=yc=0, xe=ye=11 (out_valid in the next cycle).
  - Otherwise go to EXEC.
- EXEC (1 cycle): each channel forms the post-negation operands.
  - Negation is two's complement mod 2^W; ctl 100 negates A, ctl 010 negates B.
  - A W-bit ripple add follows, in both primary and shadow, with Hamming single-bit correction on the sum.
  - The four sum+carry results are registered at the end of the cycle. Next state is CHECK.
- CHECK (1 cycle): a channel is clean when primary==shadow (sum and carry).
  - Both clean and X==Y: go to DONE, both codes 10.
  - Otherwise, if retry count<RETRY_MAX: increment and go to EXEC.
  - Otherwise go to DONE. A clean channel gets 10 with its primary result; a mismatching channel gets 01 with its primary result.
- DONE: out_valid=1. x, y, xc, yc, xe, ye hold stable while out_ready=0. When out_valid&out_ready at the edge: go to IDLE, out_valid=0, outputs keep their last values.
- Latency, accept edge = cycle 0:
  - Clean path: out_valid in cycle 3.
  - Each retry: +2 cycles.
  - Input error: out_valid in cycle 1.
- Throughput: one transaction in flight; in_ready=0 outside IDLE.
- Carry is the carry-out of the final W-bit add only; the negation increment carry is discarded.
- Simultaneous out_ready and in_valid in DONE: the result completes; the new operand is not accepted until IDLE (next cycle).
- Control 000 or multi-hot counts as an input error even when parity is valid.

Optional Feature:
- Macro FT_ALU_ERR_CNT_EN.
- When defined: adds output port err_cnt (8 bits), reset 0. It increments by 1 at each completed transfer (out_valid&out_ready) where xe≠10 or ye≠10, and saturates at 255.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- W=3: a=3, b=2, ctl=001, par=0 → cycle 3: out_valid=1, x=y=5, xc=yc=0, xe=ye=10.
- a=5, b=3, ctl=010, par=1 → x=y=2, xc=yc=1, xe=ye=10. Then a=1, b=2, ctl=100, par=1 → x=y=1, xc=yc=1.
- ctl=011 with valid parity, and separately a=3, b=2, ctl=001, par=1 → out_valid in cycle 1, x=y=0, xe=ye=11, err_cnt increments (if enabled).
- Force the X shadow sum bit0 inverted for the first EXEC only → one retry, out_valid in cycle 5, xe=ye=10. Force it permanently with RETRY_MAX=2 → out_valid in cycle 7, xe=01, ye=10.
- Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, in_valid ignored. Release → IDLE next cycle.
- Assert rst during EXEC → out_valid=0 and all outputs zero immediately, in_ready=1 after release, no stale result is emitted. Saturation: 260 error transfers → err_cnt=255.
